ce_arbiter: RTL and testbench

CE_ARBITER -- requirements
Module: ce_arbiter

---
 rtl/ce_arb_pkg.sv | 20 ++
 rtl/ce_arbiter_rr_pick.sv | 36 +++
 rtl/ce_arbiter.sv | 140 ++++++++++++++
 tb/tb_ce_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/ce_arb_pkg.sv
// Purpose : shared types and default sizing for the ce_arbiter block.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   arb_state_t  - arbiter FSM state (IDLE, GRANT, LOCKED)
//   *_DEF        - default values for NUM_REQ, DATA_W and MAX_LOCK
package ce_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      LOCKED = 2'd2
   } arb_state_t;

   localparam int NUM_REQ_DEF  = 4;
   localparam int DATA_W_DEF   = 8;
   localparam int MAX_LOCK_DEF = 8;

endpackage

// File: rtl/ce_arbiter_rr_pick.sv
// Purpose : round-robin winner search, first set req bit at or above ptr, wrapping.
// Latency : purely combinational, no registers.
// Backpressure: none; vld is low when no request is set.
//
// Ports:
//   req - request vector, one bit per requester
//   ptr - index of the highest-priority requester this cycle
//   win - index of the selected requester (0 when vld is low)
//   vld - at least one request is set
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [PTR_W-1:0]   win,
   output logic               vld
);

   always_comb begin
      int idx;
      win = '0;
      vld = 1'b0;
      idx = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // Explicit wrap so non-power-of-two NUM_REQ never indexes past the top.
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!vld && req[idx]) begin
            win = PTR_W'(idx);
            vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ce_arbiter.sv
// Purpose : round-robin arbiter loading one requester's data into a shared register.
// Latency : 1 cycle from REQ sampled to GNT/CE/Q; all outputs registered.
// Backpressure: none; losing requesters keep REQ high and are served in rotation.
//
// Optional feature macro: CE_ARB_LOCK_EN (adds LOCK port, LOCKED state, lock counter).
// Ports:
//   CK   - rising-edge clock
//   SR   - synchronous active-high reset
//   REQ  - level request per requester
//   D    - packed data, requester i at [i*DATA_W +: DATA_W]
//   LOCK - per-requester hold request (CE_ARB_LOCK_EN builds only)
//   GNT  - registered one-hot grant, zero when idle
//   CE   - registered load strobe, OR of GNT
//   Q    - shared registered data
module ce_arbiter
   import ce_arb_pkg::*;
#(
   parameter int NUM_REQ  = NUM_REQ_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_LOCK = MAX_LOCK_DEF
) (
   input  logic                      CK,
   input  logic                      SR,
   input  logic [NUM_REQ-1:0]        REQ,
   input  logic [NUM_REQ*DATA_W-1:0] D,
`ifdef CE_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]        LOCK,
`endif
   output logic [NUM_REQ-1:0]        GNT,
   output logic                      CE,
   output logic [DATA_W-1:0]         Q
);

   localparam int PTR_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 16 || DATA_W < 1 || MAX_LOCK < 2 || MAX_LOCK > 255) begin : g_bad_param
      $error("ce_arbiter: parameter out of range");
   end

   arb_state_t          state, state_nxt;
   logic [PTR_W-1:0]    ptr, ptr_nxt;
   logic [NUM_REQ-1:0]  gnt_nxt;
   logic                ce_nxt;
   logic [DATA_W-1:0]   q_nxt;
   logic [PTR_W-1:0]    pick_win;
   logic                pick_vld;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .req (REQ),
      .ptr (ptr),
      .win (pick_win),
      .vld (pick_vld)
   );

`ifdef CE_ARB_LOCK_EN
   logic [PTR_W-1:0] gidx, gidx_nxt;
   logic [7:0]       lock_cnt, lock_cnt_nxt;
   logic             hold;

   // The current holder keeps the grant while it still requests and locks,
   // capped at MAX_LOCK consecutive granted cycles (lock_cnt counts them).
   assign hold = (state != IDLE) && REQ[gidx] && LOCK[gidx] &&
                 (int'(lock_cnt) < MAX_LOCK);
`endif

   // State and output registers.
   always_ff @(posedge CK) begin
      if (SR) begin
         state <= IDLE;
         ptr   <= '0;
         GNT   <= '0;
         CE    <= 1'b0;
         Q     <= '0;
`ifdef CE_ARB_LOCK_EN
         gidx     <= '0;
         lock_cnt <= '0;
`endif
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         GNT   <= gnt_nxt;
         CE    <= ce_nxt;
         Q     <= q_nxt;
`ifdef CE_ARB_LOCK_EN
         gidx     <= gidx_nxt;
         lock_cnt <= lock_cnt_nxt;
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE, GRANT: state_nxt = pick_vld ? GRANT : IDLE;
`ifdef CE_ARB_LOCK_EN
         LOCKED:      state_nxt = pick_vld ? GRANT : IDLE;
`endif
         default:     state_nxt = IDLE;
      endcase
`ifdef CE_ARB_LOCK_EN
      if (hold) state_nxt = LOCKED;
`endif
   end

   // Next values of the registered outputs and the rotation pointer.
   always_comb begin
      gnt_nxt = '0;
      ce_nxt  = 1'b0;
      q_nxt   = Q;
      ptr_nxt = ptr;
`ifdef CE_ARB_LOCK_EN
      gidx_nxt     = gidx;
      lock_cnt_nxt = '0;
      if (hold) begin
         // Pointer already sits at holder+1 from the original grant.
         gnt_nxt      = GNT;
         ce_nxt       = 1'b1;
         q_nxt        = D[int'(gidx)*DATA_W +: DATA_W];
         lock_cnt_nxt = lock_cnt + 8'd1;
      end else
`endif
      if (pick_vld) begin
         gnt_nxt = NUM_REQ'(1) << pick_win;
         ce_nxt  = 1'b1;
         q_nxt   = D[int'(pick_win)*DATA_W +: DATA_W];
         // Winner drops to lowest priority on the next arbitration.
         if (int'(pick_win) == NUM_REQ - 1) ptr_nxt = '0;
         else                               ptr_nxt = pick_win + PTR_W'(1);
`ifdef CE_ARB_LOCK_EN
         gidx_nxt     = pick_win;
         lock_cnt_nxt = 8'd1;
`endif
      end
   end

endmodule

// File: tb/tb_ce_arbiter.sv
// Directed bench for ce_arbiter with NUM_REQ=4, DATA_W=8, MAX_LOCK=4.
module tb_ce_arbiter;

   logic        CK;
   logic        SR;
   logic [3:0]  REQ;
   logic [31:0] D;
`ifdef CE_ARB_LOCK_EN
   logic [3:0]  LOCK;
`endif
   logic [3:0]  GNT;
   logic        CE;
   logic [7:0]  Q;

   int tests;
   int fails;

   ce_arbiter #(
      .NUM_REQ  (4),
      .DATA_W   (8),
      .MAX_LOCK (4)
   ) dut (
      .CK   (CK),
      .SR   (SR),
      .REQ  (REQ),
      .D    (D),
`ifdef CE_ARB_LOCK_EN
      .LOCK (LOCK),
`endif
      .GNT  (GNT),
      .CE   (CE),
      .Q    (Q)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then sample away from it.
   task automatic edge_step();
      @(posedge CK);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [3:0] g, input logic c, input logic [7:0] q);
      check({tag, ".gnt"}, 32'(GNT), 32'(g));
      check({tag, ".ce"},  32'(CE),  32'(c));
      check({tag, ".q"},   32'(Q),   32'(q));
   endtask

   initial begin
      tests = 0;
      fails = 0;
      SR  = 1'b1;
      REQ = 4'b0000;
      D   = 32'h0;
`ifdef CE_ARB_LOCK_EN
      LOCK = 4'b0000;
`endif

      // Reset for two edges, then idle.
      edge_step(); expect_out("rst0", 4'b0000, 1'b0, 8'h00);
      edge_step(); expect_out("rst1", 4'b0000, 1'b0, 8'h00);
      SR = 1'b0;
      edge_step(); expect_out("idle", 4'b0000, 1'b0, 8'h00);

      // Single request from requester 2.
      D   = {8'h13, 8'hA5, 8'h11, 8'h10};
      REQ = 4'b0100;
      edge_step(); expect_out("single", 4'b0100, 1'b1, 8'hA5);
      REQ = 4'b0000;
      edge_step(); expect_out("single_idle", 4'b0000, 1'b0, 8'hA5);

      // Full rotation from a fresh reset.
      SR = 1'b1;
      edge_step(); expect_out("rst2", 4'b0000, 1'b0, 8'h00);
      SR  = 1'b0;
      D   = {8'h13, 8'h12, 8'h11, 8'h10};
      REQ = 4'b1111;
      edge_step(); expect_out("rr0", 4'b0001, 1'b1, 8'h10);
      edge_step(); expect_out("rr1", 4'b0010, 1'b1, 8'h11);
      edge_step(); expect_out("rr2", 4'b0100, 1'b1, 8'h12);
      edge_step(); expect_out("rr3", 4'b1000, 1'b1, 8'h13);
      edge_step(); expect_out("rr4", 4'b0001, 1'b1, 8'h10);

      // Reset in the middle of traffic overrides the pending grant.
      SR = 1'b1;
      edge_step(); expect_out("rst_mid0", 4'b0000, 1'b0, 8'h00);
      SR = 1'b0;
      edge_step(); expect_out("rr_a", 4'b0001, 1'b1, 8'h10);
      edge_step(); expect_out("rr_b", 4'b0010, 1'b1, 8'h11);
      edge_step(); expect_out("rr_c", 4'b0100, 1'b1, 8'h12);
      SR = 1'b1;
      edge_step(); expect_out("rst_mid1", 4'b0000, 1'b0, 8'h00);
      SR = 1'b0;
      edge_step(); expect_out("post_rst", 4'b0001, 1'b1, 8'h10);

      // Pointer is now 1; two requesters contend.
      REQ = 4'b0011;
`ifdef CE_ARB_LOCK_EN
      LOCK = 4'b0010;
      edge_step(); expect_out("lk0", 4'b0010, 1'b1, 8'h11);
      edge_step(); expect_out("lk1", 4'b0010, 1'b1, 8'h11);
      edge_step(); expect_out("lk2", 4'b0010, 1'b1, 8'h11);
      edge_step(); expect_out("lk3", 4'b0010, 1'b1, 8'h11);
      edge_step(); expect_out("lk_rel", 4'b0001, 1'b1, 8'h10);
      edge_step(); expect_out("lk_again", 4'b0010, 1'b1, 8'h11);

      // Lock dropped during the hold releases to normal arbitration.
      SR = 1'b1;
      edge_step(); expect_out("rst_lk", 4'b0000, 1'b0, 8'h00);
      SR = 1'b0;
      edge_step(); expect_out("lkd0", 4'b0001, 1'b1, 8'h10);
      edge_step(); expect_out("lkd1", 4'b0010, 1'b1, 8'h11);
      edge_step(); expect_out("lkd2", 4'b0010, 1'b1, 8'h11);
      edge_step(); expect_out("lkd3", 4'b0010, 1'b1, 8'h11);
      LOCK = 4'b0000;
      edge_step(); expect_out("lk_drop", 4'b0001, 1'b1, 8'h10);
`else
      edge_step(); expect_out("alt0", 4'b0010, 1'b1, 8'h11);
      edge_step(); expect_out("alt1", 4'b0001, 1'b1, 8'h10);
      edge_step(); expect_out("alt2", 4'b0010, 1'b1, 8'h11);
      edge_step(); expect_out("alt3", 4'b0001, 1'b1, 8'h10);
`endif

      // Idle holds Q.
      REQ = 4'b0000;
      edge_step(); expect_out("end_idle", 4'b0000, 1'b0, 8'h10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
